// File: rtl/cp0_port_ctrl.sv
// CP0 port controller: request channel, 1-entry write buffer, MFC0 responses, timer interrupt latch.
// Build option: CP0_FWD_EN lets reads pass a full write buffer, forwarding buffered data on an address match.
module cp0_port_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic        exc_valid,
  input  logic [31:0] exc_badvaddr,
  output logic        cp0_wen,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic [4:0]  cp0_raddr,
  input  logic [31:0] cp0_rdata,
  input  logic        timer_int,
  output logic        int_pending,
  input  logic        int_ack
);

  localparam logic [4:0] BADVADDR_ADDR = 5'd8;

  logic        r_live;
  logic        r_wb_valid;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        r_rd_valid;
  logic [4:0]  r_rd_addr;
  logic [1:0]  r_sync;
  logic        r_sync_prev;
  logic        r_int_pending;

  logic        w_wr_acc;
  logic        w_rd_acc;
  logic        w_exc;
  logic        w_drain;
  logic        w_rise;

  // r_live holds req_ready low until the first edge after reset releases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

`ifdef CP0_FWD_EN
  assign req_ready = r_live & (~r_wb_valid | ~req_we);
`else
  assign req_ready = r_live & ~r_wb_valid;
`endif

  assign w_wr_acc = req_valid & req_ready & req_we;
  assign w_rd_acc = req_valid & req_ready & ~req_we;
  assign w_exc    = exc_valid & r_live;
  assign w_drain  = r_wb_valid & ~w_exc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (w_wr_acc) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= req_addr;
      r_wb_data  <= req_wdata;
    end else if (w_drain) begin
      r_wb_valid <= 1'b0;
    end
  end

  // BadVAddr update pre-empts the buffer drain for that cycle
  assign cp0_wen   = w_exc | r_wb_valid;
  assign cp0_waddr = w_exc ? BADVADDR_ADDR : (r_wb_valid ? r_wb_addr : 5'd0);
  assign cp0_wdata = w_exc ? exc_badvaddr  : (r_wb_valid ? r_wb_data : 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_addr <= req_addr;
    end
  end

  assign resp_valid = r_rd_valid;
  assign cp0_raddr  = r_rd_valid ? r_rd_addr : 5'd0;

`ifdef CP0_FWD_EN
  logic        r_fwd_hit;
  logic [31:0] r_fwd_data;

  // forwarded data is frozen at acceptance, the buffer may drain before the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit  <= w_rd_acc & r_wb_valid & (req_addr == r_wb_addr);
      if (w_rd_acc) r_fwd_data <= r_wb_data;
    end
  end

  assign resp_rdata = !r_rd_valid ? 32'd0 : (r_fwd_hit ? r_fwd_data : cp0_rdata);
`else
  assign resp_rdata = r_rd_valid ? cp0_rdata : 32'd0;
`endif

  assign w_rise = r_sync[1] & ~r_sync_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync        <= 2'b00;
      r_sync_prev   <= 1'b0;
      r_int_pending <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], timer_int};
      r_sync_prev   <= r_sync[1];
      if (w_rise)       r_int_pending <= 1'b1;
      else if (int_ack) r_int_pending <= 1'b0;
    end
  end

  assign int_pending = r_int_pending;

endmodule
